// File: rtl/lc3_control_fsm.sv
`timescale 1ns/1ps
// LC-3 multicycle control unit: fetch/decode/execute sequencer with a
// parametrised memory wait-state counter, NZP branch evaluation and
// halt / illegal-opcode handling. Outputs are decoded from the registered
// state, IR and wait counter; all of them are forced low while reset is held.
module lc3_control_fsm #(
    parameter int MEM_WAIT     = 0,
    parameter int HALT_ON_TRAP = 1,
    parameter int WAIT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] IR,
    input  logic        N,
    input  logic        Z,
    input  logic        P,
    output logic [1:0]  aluControl,
    output logic        enaALU,
    output logic        enaMARM,
    output logic        enaMDR,
    output logic        enaPC,
    output logic        ldPC,
    output logic        ldIR,
    output logic        ldMAR,
    output logic        ldMDR,
    output logic        ldCC,
    output logic [1:0]  selPC,
    output logic        selEAB1,
    output logic [1:0]  selEAB2,
    output logic        selMAR,
    output logic        selMDR,
    output logic [2:0]  SR1,
    output logic [2:0]  SR2,
    output logic [2:0]  DR,
    output logic        regWE,
    output logic        memWE,
    output logic        halted,
    output logic        illegal
);

    typedef enum logic [3:0] {
        S_FETCH0, S_FETCH1, S_FETCH2, S_DECODE,
        S_EXEC_ALU, S_BR, S_JMP, S_LEA,
        S_ADDR_LD, S_ADDR_ST, S_RD, S_WB,
        S_ST_DATA, S_WR, S_HALT
    } state_t;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    // Value of the wait counter on the final cycle of a memory access state.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic [3:0]        op;
    logic              mem_last;
    logic              br_taken;
    logic              unused_ir;

    assign op        = IR[15:12];
    assign mem_last  = (cnt_q == WAIT_LAST);
    assign br_taken  = (IR[11] & N) | (IR[10] & Z) | (IR[9] & P);
    // IR[5:3] (imm5 / SR2 mode bits) are interpreted by the datapath only.
    assign unused_ir = ^IR[5:3];

    // State register and wait counter; reset returns to FETCH0 mid-access.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, wait counter and Moore-style control decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        aluControl = 2'b00;
        enaALU     = 1'b0;
        enaMARM    = 1'b0;
        enaMDR     = 1'b0;
        enaPC      = 1'b0;
        ldPC       = 1'b0;
        ldIR       = 1'b0;
        ldMAR      = 1'b0;
        ldMDR      = 1'b0;
        ldCC       = 1'b0;
        selPC      = 2'b00;
        selEAB1    = 1'b0;
        selEAB2    = 2'b00;
        selMAR     = 1'b0;
        selMDR     = 1'b0;
        SR1        = IR[8:6];
        SR2        = IR[2:0];
        DR         = IR[11:9];
        regWE      = 1'b0;
        memWE      = 1'b0;
        halted     = 1'b0;
        illegal    = 1'b0;

        unique case (state_q)
            S_FETCH0: begin
                enaPC   = 1'b1;
                ldMAR   = 1'b1;
                ldPC    = 1'b1;
                selPC   = 2'b00;
                state_d = S_FETCH1;
            end
            S_FETCH1: begin
                selMDR = 1'b1;
                if (mem_last) begin
                    ldMDR   = 1'b1;
                    state_d = S_FETCH2;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FETCH2: begin
                enaMDR  = 1'b1;
                ldIR    = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    OP_ADD, OP_AND, OP_NOT: state_d = S_EXEC_ALU;
                    OP_BR:                  state_d = S_BR;
                    OP_JMP:                 state_d = S_JMP;
                    OP_LEA:                 state_d = S_LEA;
                    OP_LD, OP_LDR:          state_d = S_ADDR_LD;
                    OP_ST, OP_STR:          state_d = S_ADDR_ST;
                    OP_TRAP:                state_d = (HALT_ON_TRAP != 0) ? S_HALT : S_FETCH0;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH0;
                    end
                endcase
            end
            S_EXEC_ALU: begin
                case (op)
                    OP_ADD:  aluControl = 2'b00;
                    OP_AND:  aluControl = 2'b01;
                    default: aluControl = 2'b10;
                endcase
                enaALU  = 1'b1;
                regWE   = 1'b1;
                ldCC    = 1'b1;
                state_d = S_FETCH0;
            end
            S_BR: begin
                if (br_taken) begin
                    ldPC    = 1'b1;
                    selPC   = 2'b01;
                    selEAB1 = 1'b0;
                    selEAB2 = 2'b10;
                end
                state_d = S_FETCH0;
            end
            S_JMP: begin
                ldPC    = 1'b1;
                selPC   = 2'b01;
                selEAB1 = 1'b1;
                selEAB2 = 2'b00;
                state_d = S_FETCH0;
            end
            S_LEA: begin
                enaMARM = 1'b1;
                selMAR  = 1'b0;
                selEAB1 = 1'b0;
                selEAB2 = 2'b10;
                regWE   = 1'b1;
                ldCC    = 1'b1;
                state_d = S_FETCH0;
            end
            S_ADDR_LD, S_ADDR_ST: begin
                ldMAR  = 1'b1;
                selMAR = 1'b0;
                // PC-relative (LD/ST) versus base+offset6 (LDR/STR).
                if (op == OP_LD || op == OP_ST) begin
                    selEAB1 = 1'b0;
                    selEAB2 = 2'b10;
                end else begin
                    selEAB1 = 1'b1;
                    selEAB2 = 2'b01;
                end
                state_d = (state_q == S_ADDR_LD) ? S_RD : S_ST_DATA;
            end
            S_RD: begin
                selMDR = 1'b1;
                if (mem_last) begin
                    ldMDR   = 1'b1;
                    state_d = S_WB;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WB: begin
                enaMDR  = 1'b1;
                regWE   = 1'b1;
                ldCC    = 1'b1;
                state_d = S_FETCH0;
            end
            S_ST_DATA: begin
                // Store source register is routed through the ALU pass path.
                SR1        = IR[11:9];
                aluControl = 2'b11;
                enaALU     = 1'b1;
                ldMDR      = 1'b1;
                selMDR     = 1'b0;
                state_d    = S_WR;
            end
            S_WR: begin
                memWE = 1'b1;
                if (mem_last) begin
                    state_d = S_FETCH0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HALT: begin
                halted  = 1'b1;
                state_d = S_HALT;
            end
            default: state_d = S_FETCH0;
        endcase

        // Everything is held quiet while reset is asserted.
        if (!reset) begin
            aluControl = 2'b00;
            enaALU     = 1'b0;
            enaMARM    = 1'b0;
            enaMDR     = 1'b0;
            enaPC      = 1'b0;
            ldPC       = 1'b0;
            ldIR       = 1'b0;
            ldMAR      = 1'b0;
            ldMDR      = 1'b0;
            ldCC       = 1'b0;
            selPC      = 2'b00;
            selEAB1    = 1'b0;
            selEAB2    = 2'b00;
            selMAR     = 1'b0;
            selMDR     = 1'b0;
            SR1        = 3'b000;
            SR2        = 3'b000;
            DR         = 3'b000;
            regWE      = 1'b0;
            memWE      = 1'b0;
            halted     = 1'b0;
            illegal    = 1'b0;
        end
    end

endmodule

// File: doc/lc3_control_fsm.md
Name: lc3_control_fsm

Overview:
Multicycle LC-3 control unit driving the existing datapath through its bus-enable, load and mux-select signals. It adds a real sequencer: fetch/decode/execute state machine, a parametrised memory wait-state counter, condition-code-driven branching, and halt/illegal-opcode handling. It sits between the instruction register and N/Z/P flags on one side and the datapath/memory controls on the other.

Parameters:
MEM_WAIT, 0, extra cycles each memory access state is held (0..15)
HALT_ON_TRAP, 1, 1: TRAP (1111) enters HALT; 0: TRAP is a NOP
WAIT_W, 4, width of the wait counter; must hold MEM_WAIT

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-low reset
IR  in  16  instruction register contents
N, Z, P  in  1 each  registered condition codes
aluControl  out  2  00 ADD, 01 AND, 10 NOT, 11 pass SR1
enaALU, enaMARM, enaMDR, enaPC  out  1 each  bus tri-state enables, at most one high per cycle
ldPC, ldIR, ldMAR, ldMDR, ldCC  out  1 each  register load strobes
selPC  out  2  00 PC+1, 01 EAB, 10 bus
selEAB1  out  1  0 PC, 1 SR1 register
selEAB2  out  2  00 zero, 01 sext IR[5:0], 10 sext IR[8:0], 11 sext IR[10:0]
selMAR  out  1  0 EAB, 1 zext IR[7:0]
selMDR  out  1  0 bus, 1 memory read data
SR1, SR2, DR  out  3 each  register file addresses
regWE, memWE  out  1 each  register-file / memory write enable
halted  out  1  high while in HALT
illegal  out  1  one-cycle pulse on unsupported opcode

Behaviour:
- Reset (reset=0 at clk edge): state=FETCH0, wait counter=0; all strobes/enables/WEs/halted/illegal 0, all selects 0. Outputs are Moore-decoded from state (+IR, +counter); glitch-free registered state.
- Default every cycle: strobes/enables 0; SR1=IR[8:6], SR2=IR[2:0], DR=IR[11:9].
- FETCH0: enaPC, ldMAR, ldPC, selPC=00 -> FETCH1.
- FETCH1 (memory read): selMDR=1; counter counts 0..MEM_WAIT; ldMDR only on final cycle; then counter clears -> FETCH2.
- FETCH2: enaMDR, ldIR -> DECODE.
- DECODE on IR[15:12]: 0001/0101/1001 -> EXEC_ALU; 0000 -> BR; 1100 -> JMP; 1110 -> LEA; 0010/0110 -> ADDR_LD; 0011/0111 -> ADDR_ST; 1111 -> HALT if HALT_ON_TRAP else FETCH0; anything else -> FETCH0 with illegal=1 for this cycle.
- EXEC_ALU: aluControl from opcode (ADD 00, AND 01, NOT 10); enaALU, regWE, ldCC -> FETCH0. Immediate selection via IR[5] is datapath-side.
- BR: taken = (IR[11]&N)|(IR[10]&Z)|(IR[9]&P). If taken: ldPC, selPC=01, selEAB1=0, selEAB2=10. -> FETCH0. BR with nzp=000 is never taken.
- JMP: ldPC, selPC=01, selEAB1=1, selEAB2=00 -> FETCH0.
- LEA: enaMARM, selMAR=0, selEAB1=0, selEAB2=10, regWE, ldCC -> FETCH0.
- ADDR_LD/ADDR_ST: ldMAR, selMAR=0; LD/ST selEAB1=0,selEAB2=10; LDR/STR selEAB1=1,selEAB2=01. -> RD or ST_DATA.
- RD: as FETCH1 (wait counter, ldMDR on last cycle) -> WB.
- WB: enaMDR, regWE, ldCC -> FETCH0.
- ST_DATA: SR1=IR[11:9], aluControl=11, enaALU, ldMDR, selMDR=0 -> WR.
- WR: memWE high for all MEM_WAIT+1 cycles -> FETCH0.
- HALT: halted=1, no strobes; held until reset.
- Counter never exceeds MEM_WAIT; cleared on every state exit and by reset mid-access (no partial memWE after reset).
- Cycle counts (MEM_WAIT=0): ALU/BR/JMP/LEA 5, LD/LDR 7, ST/STR 7; each memory access adds MEM_WAIT.

Test Plan:
- Reset held 3 cycles then released with IR=16'h1042 (ADD R0,R1,R2), MEM_WAIT=0 -> FETCH0 on first cycle; EXEC_ALU on cycle 5 with regWE=1, ldCC=1, aluControl=00, DR=0, SR1=1, SR2=2.
- IR=16'h0A05 (BRnp), N=0,Z=1,P=0 -> BR state with ldPC=0; repeat with N=1 -> ldPC=1, selPC=01, selEAB2=10.
- MEM_WAIT=3, IR=16'h6283 (LDR R1,R2,#3) -> FETCH1 and RD each last 4 cycles, ldMDR high only on 4th; WB has DR=1, regWE=1; total 13 cycles.
- IR=16'h7283 (STR R1,R2,#3), MEM_WAIT=2 -> ST_DATA SR1=1, aluControl=11; WR memWE high exactly 3 cycles.
- IR=16'hD000 -> illegal pulses 1 cycle in DECODE, returns to FETCH0; IR=16'hF025 with HALT_ON_TRAP=1 -> halted=1 stays until reset=0.
- Assert reset=0 in 2nd cycle of RD with MEM_WAIT=3 -> next cycle FETCH0, all strobes 0, counter 0.
